// File: rtl/spk_pkg.sv
// Shared constants and types for the combined-word transmitter.
// Bank/slot geometry, cfg selector codes, error bit indices, collector state.
package spk_pkg;

  localparam int NUM_BANK    = 5;
  localparam int CH_PER_BANK = 32;
  localparam int NUM_CH      = NUM_BANK * CH_PER_BANK;
  localparam int CH_W        = 8;
  localparam int BANK_W      = 3;
  localparam int SLOT_W      = 5;
  localparam int LANE_CH_W   = 12;
  localparam int DW          = 32;

  localparam logic [1:0] CFG_THR = 2'd0;
  localparam logic [1:0] CFG_OFF = 2'd1;
  localparam logic [1:0] CFG_GRP = 2'd2;
  localparam logic [1:0] CFG_RSV = 2'd3;

  localparam int ERR_RANGE = 0;
  localparam int ERR_SLOT  = 1;
  localparam int ERR_DUP   = 2;
  localparam int ERR_EOF   = 3;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PARTIAL = 1'b1
  } col_state_t;

endpackage

// File: rtl/mua_cfg_ram.sv
// 32x32 synchronous RAM, independent write and read ports.
// Read-first: a same-address write lands after the read samples.
module mua_cfg_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/mua_comb_tx.sv
// Packs serial per-channel samples into 5-bank combined words with table data.
// Optional MUA_COMB_TX_ERR_CNT_EN adds saturating per-error event counters.
module mua_comb_tx
  import spk_pkg::*;
(
  input  logic         bus_clk,
  input  logic         bus_rst,
  input  logic         tx_en,
  input  logic         fir_valid,
  input  logic [7:0]   fir_ch,
  input  logic [31:0]  fir_data,
  input  logic         fir_eof,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_sel,
  input  logic [7:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  output logic         mua_comb_valid,
  output logic [59:0]  mua_comb_ch,
  output logic [159:0] mua_comb_data,
  output logic [159:0] threshold_comb,
  output logic [159:0] off_set_comb,
  output logic [159:0] ch_unigroup_comb,
  output logic         mua_comb_eof,
`ifdef MUA_COMB_TX_ERR_CNT_EN
  output logic [63:0]  err_cnt,
`endif
  output logic [3:0]   err_flags
);

  col_state_t          state;
  logic [SLOT_W-1:0]   cur_slot;
  logic [NUM_BANK-1:0] mask;
  logic [DW-1:0]       bank_data [NUM_BANK];

  logic                hit;
  logic                bad_ch;
  logic                acc;
  logic [BANK_W-1:0]   in_bank;
  logic [SLOT_W-1:0]   in_slot;
  logic [NUM_BANK-1:0] bank_bit;
  logic [NUM_BANK-1:0] nmask;
  logic                restart;
  logic                slot_err;
  logic                dup_err;
  logic                complete;
  logic                eof_err;
  logic [3:0]          err_ev;
  logic [NUM_BANK*DW-1:0] word;

  assign hit      = tx_en & fir_valid;
  assign bad_ch   = hit & (fir_ch >= 8'(NUM_CH));
  assign acc      = hit & ~bad_ch;
  assign in_bank  = fir_ch[CH_W-1:SLOT_W];
  assign in_slot  = fir_ch[SLOT_W-1:0];
  assign bank_bit = acc ? (NUM_BANK'(1) << in_bank) : '0;

  assign restart  = (state == ST_EMPTY) | (in_slot != cur_slot);
  assign slot_err = acc & (state == ST_PARTIAL) & (in_slot != cur_slot);
  assign dup_err  = acc & ~restart & (|(mask & bank_bit));
  assign nmask    = restart ? bank_bit : (mask | bank_bit);
  assign complete = acc & (&nmask);
  assign eof_err  = acc & fir_eof & ~complete;

  assign err_ev[ERR_RANGE] = bad_ch;
  assign err_ev[ERR_SLOT]  = slot_err;
  assign err_ev[ERR_DUP]   = dup_err;
  assign err_ev[ERR_EOF]   = eof_err;

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state    <= ST_EMPTY;
      mask     <= '0;
      cur_slot <= '0;
    end else if (acc) begin
      cur_slot <= in_slot;
      if (complete | fir_eof) begin
        state <= ST_EMPTY;
        mask  <= '0;
      end else begin
        state <= ST_PARTIAL;
        mask  <= nmask;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    for (int b = 0; b < NUM_BANK; b++)
      if (bank_bit[b])
        bank_data[b] <= fir_data;
  end

  // The completing sample bypasses its bank register.
  always_comb begin
    word = '0;
    for (int b = 0; b < NUM_BANK; b++)
      word[DW*b +: DW] = bank_bit[b] ? fir_data : bank_data[b];
  end

  logic                s1_valid;
  logic                s1_eof;
  logic [SLOT_W-1:0]   s1_slot;
  logic [NUM_BANK*DW-1:0] s1_data;

  always_ff @(posedge bus_clk) begin
    if (bus_rst)
      s1_valid <= 1'b0;
    else
      s1_valid <= complete;
  end

  always_ff @(posedge bus_clk) begin
    if (complete) begin
      s1_data <= word;
      s1_slot <= in_slot;
      s1_eof  <= fir_eof;
    end
  end

  logic          cfg_ok;
  logic [DW-1:0] rq [3][NUM_BANK];

  assign cfg_ok = cfg_we & (cfg_addr < 8'(NUM_CH)) & (cfg_sel != CFG_RSV);

  for (genvar k = 0; k < 3; k++) begin : g_tab
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      mua_cfg_ram u_ram (
        .clk   (bus_clk),
        .we    (cfg_ok && cfg_sel == 2'(k)
                && cfg_addr[CH_W-1:SLOT_W] == 3'(b)),
        .waddr (cfg_addr[SLOT_W-1:0]),
        .wdata (cfg_wdata),
        .re    (complete),
        .raddr (in_slot),
        .rdata (rq[k][b])
      );
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      mua_comb_valid   <= 1'b0;
      mua_comb_ch      <= '0;
      mua_comb_data    <= '0;
      threshold_comb   <= '0;
      off_set_comb     <= '0;
      ch_unigroup_comb <= '0;
      mua_comb_eof     <= 1'b0;
    end else begin
      mua_comb_valid <= s1_valid;
      if (s1_valid) begin
        mua_comb_data <= s1_data;
        mua_comb_eof  <= s1_eof;
        for (int b = 0; b < NUM_BANK; b++) begin
          mua_comb_ch[LANE_CH_W*b +: LANE_CH_W] <= {4'd0, 3'(b), s1_slot};
          threshold_comb[DW*b +: DW]   <= rq[0][b];
          off_set_comb[DW*b +: DW]     <= rq[1][b];
          ch_unigroup_comb[DW*b +: DW] <= rq[2][b];
        end
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst)
      err_flags <= '0;
    else
      err_flags <= err_flags | err_ev;
  end

`ifdef MUA_COMB_TX_ERR_CNT_EN
  always_ff @(posedge bus_clk) begin
    if (bus_rst)
      err_cnt <= '0;
    else
      for (int k = 0; k < 4; k++)
        if (err_ev[k] && err_cnt[16*k +: 16] != 16'hFFFF)
          err_cnt[16*k +: 16] <= err_cnt[16*k +: 16] + 16'd1;
  end
`endif

endmodule
